// File: rtl/qarma_feeder.sv
// qarma_feeder: packs a stream of W-bit words into one key/tweak/plaintext frame for a
// registered QARMA core and returns its ciphertext on a valid/ready port. Optional: QARMA_KEY_REUSE_EN.
module qarma_feeder #(
  parameter int N   = 128,
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
`ifdef QARMA_KEY_REUSE_EN
  input  logic           in_key_reuse,
`endif
  output logic [2*N-1:0] core_K,
  output logic [N-1:0]   core_T,
  output logic [N-1:0]   core_P,
  input  logic [N-1:0]   core_C,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic [1:0]     dbg_state
);

  // Handshakes (input words and results): a transfer happens on a rising clk edge where
  // valid && ready; the source holds valid and data until then; ready never depends on valid.

  localparam int KW  = 2 * N / W;
  localparam int TW  = N / W;
  localparam int FW  = KW + 2 * TW;
  localparam int SW  = 2 * TW;
  localparam int CW  = $clog2(4 * N / W + 1);
  localparam int LW  = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int STW = 4 * N - W;

  localparam logic [CW-1:0] LAST_FULL  = CW'(FW - 1);
  localparam logic [CW-1:0] LAST_SHORT = CW'(SW - 1);
  localparam logic [LW-1:0] LAT_C      = LW'(LAT);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   wcnt;
  logic [LW-1:0]   lcnt;
  logic [STW-1:0]  stage;
  logic [4*N-1:0]  frame_word;
  logic            accept, frame_done, capture, last_word, short_cur;

  // The staging register plus the word on the bus form the whole frame; the last
  // 2N bits are always tweak then plaintext, whether or not the key was sent.
  assign frame_word = {stage, in_data};
  assign last_word  = (wcnt == (short_cur ? LAST_SHORT : LAST_FULL));
  assign dbg_state  = state;

`ifdef QARMA_KEY_REUSE_EN
  logic key_loaded, short_q;

  assign short_cur = (wcnt == '0) ? (in_key_reuse && key_loaded) : short_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_loaded <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      if (accept && (wcnt == '0)) short_q <= in_key_reuse && key_loaded;
      if (frame_done && !short_cur) key_loaded <= 1'b1;
    end
  end
`else
  assign short_cur = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    capture    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last_word) begin
          frame_done = 1'b1;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lcnt == LAT_C) begin
          capture  = 1'b1;
          state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage    <= '0;
      wcnt     <= '0;
      lcnt     <= '0;
      core_K   <= '0;
      core_T   <= '0;
      core_P   <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        if (frame_done) begin
          wcnt   <= '0;
          lcnt   <= '0;
          core_T <= frame_word[2*N-1:N];
          core_P <= frame_word[N-1:0];
          if (!short_cur) core_K <= frame_word[4*N-1:2*N];
        end else begin
          wcnt  <= wcnt + CW'(1);
          stage <= {stage[STW-W-1:0], in_data};
        end
      end
      if ((state == S_WAIT) && !capture) lcnt <= lcnt + LW'(1);
      if (capture) res_data <= core_C;
    end
  end

endmodule

// File: tb/tb_qarma_feeder.sv
// Self-checking bench for qarma_feeder: table vectors, hand-written corner sequences and
// random frames checked against a frame-level reference model with a pipelined C = P ^ T core.
module tb_qarma_feeder;

  localparam int N   = 128;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int KW  = 2 * N / W;
  localparam int TW  = N / W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
`ifdef QARMA_KEY_REUSE_EN
  logic           in_key_reuse = 1'b0;
`endif
  logic [2*N-1:0] core_K;
  logic [N-1:0]   core_T, core_P, core_C;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [N-1:0]   res_data;
  logic [1:0]     dbg_state;

  int n_cmp  = 0;
  int n_bad  = 0;
  int acc_cnt = 0;

  logic [W-1:0] tx_q[$];
  logic [N-1:0] exp_q[$];

  qarma_feeder #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
`ifdef QARMA_KEY_REUSE_EN
    .in_key_reuse (in_key_reuse),
`endif
    .core_K       (core_K),
    .core_T       (core_T),
    .core_P       (core_P),
    .core_C       (core_C),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural core: registered, C valid LAT cycles after K/T/P change.
  logic [N-1:0] c_pipe [0:LAT-1];
  always @(posedge clk) begin
    c_pipe[0] <= core_P ^ core_T;
    for (int i = 1; i < LAT; i++) c_pipe[i] <= c_pipe[i-1];
  end
  assign core_C = c_pipe[LAT-1];

  always @(posedge clk) if (rst && in_valid && in_ready) acc_cnt++;

  task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [2*N-1:0] k, input logic [N-1:0] t, input logic [N-1:0] p,
                             input bit skip_key);
    tx_q.delete();
    if (!skip_key) for (int i = 0; i < KW; i++) tx_q.push_back(k[(KW-1-i)*W +: W]);
    for (int i = 0; i < TW; i++) tx_q.push_back(t[(TW-1-i)*W +: W]);
    for (int i = 0; i < TW; i++) tx_q.push_back(p[(TW-1-i)*W +: W]);
  endtask

  // driver: mode 0 = gap-free, 1 = valid every other cycle, 2 = random gaps
  task automatic send_frame(input int mode, input int max_words);
    int  idx = 0;
    int  cyc = 0;
    logic v;
    while (idx < max_words && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = v ? tx_q[idx] : W'($urandom);
      if (v && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < max_words) check("send_timeout", idx, max_words);
  endtask

  task automatic run_frame(input logic [2*N-1:0] k, input logic [N-1:0] t, input logic [N-1:0] p,
                           input int mode, input int hold, input bit skip_key,
                           output logic [N-1:0] res);
    int start_acc, lat, bad, n0;
    logic [N-1:0] held;
    build_frame(k, t, p, skip_key);
    start_acc = acc_cnt;
    send_frame(mode, tx_q.size());
    check("words_consumed", acc_cnt - start_acc, tx_q.size());
    check("core_K", core_K, k);
    check("core_T", core_T, t);
    check("core_P", core_P, p);
    lat = 0;
    bad = 0;
    while (!res_valid && lat < 50) begin
      if (in_ready) bad++;
      tick();
      lat++;
    end
    check("latency", lat, LAT + 1);
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      if (!res_valid || res_data !== held || in_ready) bad++;
    end
    check("busy_and_stable", bad, 0);
    in_valid  = 1'b1;
    res_ready = 1'b1;
    n0 = acc_cnt;
    tick();
    res_ready = 1'b0;
    in_valid  = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("no_accept_on_hs", acc_cnt - n0, 0);
    res = held;
  endtask

  typedef struct {
    logic [2*N-1:0] k;
    logic [N-1:0]   t;
    logic [N-1:0]   p;
    int             mode;
    int             hold;
    logic [N-1:0]   exp_res;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [2*N-1:0] k;
    logic [N-1:0]   t, p, res;
    int             lat;

    tbl[0] = '{256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007,
               128'h00000010_00000011_00000012_00000013,
               128'h00000020_00000021_00000022_00000023,
               0, 0, 128'h00000030_00000030_00000030_00000030};
    tbl[1] = '{tbl[0].k, tbl[0].t, tbl[0].p, 1, 0, 128'h00000030_00000030_00000030_00000030};
    tbl[2] = '{{8{32'hFFFFFFFF}},
               128'h00000000_FFFFFFFF_12345678_9ABCDEF0,
               128'hFFFFFFFF_00000000_11111111_22222222,
               0, 10, 128'hFFFFFFFF_FFFFFFFF_03254769_B89EFCD2};

    // reset with in_valid high: nothing consumed, clean state on release
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (3) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_core_K", core_K, 0);
    check("rst_core_T", core_T, 0);
    check("rst_core_P", core_P, 0);
    check("rst_res_data", res_data, 0);
    check("rst_no_accept", acc_cnt, 0);

    // table vectors: plan frame, bubbles, backpressure
    for (int i = 0; i < 3; i++) begin
      run_frame(tbl[i].k, tbl[i].t, tbl[i].p, tbl[i].mode, tbl[i].hold, 1'b0, res);
      check($sformatf("tbl%0d_res", i), res, tbl[i].exp_res);
    end

    // mid-frame reset after 9 accepts, then a fresh frame
    build_frame(tbl[2].k, tbl[2].t, tbl[2].p, 1'b0);
    send_frame(0, 9);
    rst = 1'b0;
    tick();
    check("midrst_core_K", core_K, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b1;
    tick();
    run_frame(tbl[0].k, tbl[0].t, tbl[0].p, 0, 0, 1'b0, res);
    check("midrst_res", res, tbl[0].exp_res);

    // reset while a result is pending: result lost, core inputs cleared
    build_frame(tbl[2].k, tbl[2].t, tbl[2].p, 1'b0);
    send_frame(0, tx_q.size());
    lat = 0;
    while (!res_valid && lat < 50) begin tick(); lat++; end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("pend_rst_res_valid", res_valid, 0);
    check("pend_rst_res_data", res_data, 0);
    check("pend_rst_core_P", core_P, 0);

    // random frames against the reference model
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 2 * KW; i++) begin
        if (i < KW) k[i*W +: W] = W'($urandom);
        if (i < TW) t[i*W +: W] = W'($urandom);
        if (i < TW) p[i*W +: W] = W'($urandom);
      end
      exp_q.push_back(p ^ t);
      run_frame(k, t, p, $urandom_range(0, 2), $urandom_range(0, 4), 1'b0, res);
      check($sformatf("rand%0d_res", f), res, exp_q.pop_front());
    end

`ifdef QARMA_KEY_REUSE_EN
    // full frame loads a key; a short frame with reuse keeps it
    in_key_reuse = 1'b0;
    run_frame(tbl[2].k, tbl[0].t, tbl[0].p, 0, 0, 1'b0, res);
    check("reuse_full_res", res, tbl[0].exp_res);
    in_key_reuse = 1'b1;
    run_frame(tbl[2].k, tbl[2].t, tbl[2].p, 0, 0, 1'b1, res);
    check("reuse_short_res", res, tbl[2].exp_res);
    // after reset no key is loaded, so reuse is ignored and 16 words are needed
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_frame(tbl[0].k, tbl[2].t, tbl[2].p, 0, 0, 1'b0, res);
    check("reuse_after_rst_res", res, tbl[2].exp_res);
    in_key_reuse = 1'b0;
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
